// File: rtl/hmr_dmr_mode_ctrl.sv
// Sequences halt -> cache flush -> core resync for independent/DMR mode changes of the HMR core pair,
// counts DMR mismatches and auto-resyncs after each one, and falls back to independent mode after repeated failures.
// Latency: a request or failure is acted on in the next cycle. Backpressure: requests are held off while busy or on a failure cycle.
module hmr_dmr_mode_ctrl #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned ResetCycles   = 4,
    parameter int unsigned MaxFailures   = 3,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mode_req_valid_i,
    input  logic                mode_req_dmr_i,
    output logic                mode_req_ready_o,
    input  logic                dmr_failure_i,
    input  logic [1:0]          core_halted_i,
    input  logic [1:0]          dcache_flush_ack_i,
    input  logic [1:0]          wbuffer_empty_i,
    output logic [1:0]          core_halt_req_o,
    output logic [1:0]          dcache_flush_o,
    output logic [1:0]          core_rst_no,
    output logic                dmr_mode_active_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] fail_count_o,
    output logic                timeout_o,
    output logic                fatal_o,
    input  logic                status_clear_i
);

    localparam int unsigned TimerWidth = $clog2(TimeoutCycles + ResetCycles + 1);
    localparam logic [TimerWidth-1:0] TimeoutLast = TimerWidth'(TimeoutCycles - 1);
    localparam logic [TimerWidth-1:0] ResetLast   = TimerWidth'(ResetCycles - 1);
    localparam logic [CntWidth-1:0]   CntMax      = '1;
    localparam logic [CntWidth:0]     FailLimit   = (CntWidth + 1)'(MaxFailures);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALT   = 2'd1,
        FLUSH  = 2'd2,
        RESYNC = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  target_q, target_d;
    logic                  is_recovery_q, is_recovery_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [1:0]            flush_done_q, flush_done_d;
    logic [CntWidth-1:0]   fail_count_q, fail_count_d;
    logic                  timeout_q, timeout_d;
    logic                  fatal_q, fatal_d;

    logic                  fail_event;
    logic [1:0]            active_mask;
    logic [CntWidth-1:0]   fail_inc;
    logic                  flush_complete;

    // In DMR the pair shares cache0; cache1 is idle and needs no flush.
    assign fail_event     = mode_q & dmr_failure_i;
    assign active_mask    = mode_q ? 2'b01 : 2'b11;
    assign fail_inc       = (fail_count_q == CntMax) ? fail_count_q : fail_count_q + 1'b1;
    assign flush_complete = ((flush_done_q & active_mask) == active_mask) &&
                            ((wbuffer_empty_i & active_mask) == active_mask);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            target_q      <= 1'b0;
            is_recovery_q <= 1'b0;
            timer_q       <= '0;
            flush_done_q  <= 2'b00;
            fail_count_q  <= '0;
            timeout_q     <= 1'b0;
            fatal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            target_q      <= target_d;
            is_recovery_q <= is_recovery_d;
            timer_q       <= timer_d;
            flush_done_q  <= flush_done_d;
            fail_count_q  <= fail_count_d;
            timeout_q     <= timeout_d;
            fatal_q       <= fatal_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        target_d         = target_q;
        is_recovery_d    = is_recovery_q;
        timer_d          = timer_q;
        flush_done_d     = flush_done_q;
        fail_count_d     = fail_count_q;
        timeout_d        = timeout_q;
        fatal_d          = fatal_q;
        mode_req_ready_o = 1'b0;
        core_halt_req_o  = 2'b00;
        dcache_flush_o   = 2'b00;
        core_rst_no      = 2'b11;

        unique case (state_q)
            IDLE: begin
                mode_req_ready_o = ~fail_event;
                if (fail_event) begin
                    fail_count_d  = fail_inc;
                    is_recovery_d = 1'b1;
                    if ({1'b0, fail_inc} >= FailLimit) begin
                        target_d = 1'b0;
                        fatal_d  = 1'b1;
                    end else begin
                        target_d = 1'b1;
                    end
                    timer_d = '0;
                    state_d = HALT;
                end else if (mode_req_valid_i && (mode_req_dmr_i != mode_q)) begin
                    target_d      = mode_req_dmr_i;
                    is_recovery_d = 1'b0;
                    timer_d       = '0;
                    state_d       = HALT;
                end
                if (status_clear_i) begin
                    fail_count_d = '0;
                    timeout_d    = 1'b0;
                    fatal_d      = 1'b0;
                end
            end

            HALT, FLUSH: begin
                core_halt_req_o = 2'b11;
                timer_d         = timer_q + 1'b1;
                if (timer_q == TimeoutLast) begin
                    // A stuck recovery cannot return to a broken DMR pair: resync into independent mode.
                    timeout_d = 1'b1;
                    if (is_recovery_q) begin
                        target_d = 1'b0;
                        fatal_d  = 1'b1;
                        mode_d   = 1'b0;
                        timer_d  = '0;
                        state_d  = RESYNC;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == HALT) begin
                    if (&core_halted_i) begin
                        flush_done_d = 2'b00;
                        state_d      = FLUSH;
                    end
                end else begin
                    dcache_flush_o = active_mask & ~flush_done_q;
                    flush_done_d   = flush_done_q | (dcache_flush_ack_i & active_mask);
                    if (flush_complete) begin
                        mode_d  = target_q;
                        timer_d = '0;
                        state_d = RESYNC;
                    end
                end
            end

            RESYNC: begin
                core_halt_req_o = 2'b11;
                core_rst_no     = 2'b00;
                timer_d         = timer_q + 1'b1;
                if (timer_q == ResetLast) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmr_mode_active_o = mode_q;
    assign busy_o            = (state_q != IDLE);
    assign fail_count_o      = fail_count_q;
    assign timeout_o         = timeout_q;
    assign fatal_o           = fatal_q;

endmodule

// File: tb/tb_hmr_dmr_mode_ctrl.sv
// Randomized bench for hmr_dmr_mode_ctrl: a reactive core/cache environment plus a mode/counter reference model.
module tb_hmr_dmr_mode_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       mode_req_valid_i, mode_req_dmr_i, mode_req_ready_o;
    logic       dmr_failure_i;
    logic [1:0] core_halted_i, dcache_flush_ack_i, wbuffer_empty_i;
    logic [1:0] core_halt_req_o, dcache_flush_o, core_rst_no;
    logic       dmr_mode_active_o, busy_o, timeout_o, fatal_o, status_clear_i;
    logic [7:0] fail_count_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int ref_mode  = 0;
    int ref_cnt   = 0;
    int ref_fatal = 0;
    int ref_tmo   = 0;

    hmr_dmr_mode_ctrl #(.TimeoutCycles(1024), .ResetCycles(4), .MaxFailures(3), .CntWidth(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mode_req_valid_i(mode_req_valid_i), .mode_req_dmr_i(mode_req_dmr_i), .mode_req_ready_o(mode_req_ready_o),
        .dmr_failure_i(dmr_failure_i), .core_halted_i(core_halted_i), .dcache_flush_ack_i(dcache_flush_ack_i),
        .wbuffer_empty_i(wbuffer_empty_i), .core_halt_req_o(core_halt_req_o), .dcache_flush_o(dcache_flush_o),
        .core_rst_no(core_rst_no), .dmr_mode_active_o(dmr_mode_active_o), .busy_o(busy_o),
        .fail_count_o(fail_count_o), .timeout_o(timeout_o), .fatal_o(fatal_o), .status_clear_i(status_clear_i)
    );

    always #5 clk_i = ~clk_i;

    // Environment for one transition; the trigger was applied at the current negedge.
    task automatic run_transition(input int halt_dly, input int ack_dly0, input int ack_dly1, input int wb_dly,
                                  output logic [1:0] flush_seen, output int rst_low, output logic mode_pre,
                                  output logic mode_at_rst, output logic halt_ok, output logic done);
        int cyc = 0;
        int halt_cnt = 0;
        int wb_cnt = 0;
        int ack_cnt[2] = '{0, 0};
        int ack_dly[2];
        logic [1:0] acked = 2'b00;
        ack_dly[0] = ack_dly0;
        ack_dly[1] = ack_dly1;
        flush_seen = 2'b00; rst_low = 0; halt_ok = 1'b1; done = 1'b0; mode_at_rst = 1'bx;
        @(negedge clk_i);
        mode_req_valid_i = 1'b0;
        dmr_failure_i    = 1'b0;
        wbuffer_empty_i  = 2'b00;
        mode_pre         = dmr_mode_active_o;
        while (!done && cyc < 500) begin
            if (!busy_o) begin
                done = 1'b1;
            end else begin
                if (core_rst_no == 2'b00) begin
                    if (rst_low == 0) mode_at_rst = dmr_mode_active_o;
                    rst_low++;
                    if (core_halt_req_o != 2'b11) halt_ok = 1'b0;
                end else if (core_rst_no != 2'b11) begin
                    halt_ok = 1'b0;
                end
                flush_seen = flush_seen | dcache_flush_o;
                if (core_halt_req_o == 2'b11) halt_cnt++;
                core_halted_i = (halt_cnt >= halt_dly) ? 2'b11 : 2'b00;
                for (int i = 0; i < 2; i++) begin
                    dcache_flush_ack_i[i] = 1'b0;
                    if (dcache_flush_o[i] && !acked[i]) begin
                        ack_cnt[i]++;
                        if (ack_cnt[i] > ack_dly[i]) begin
                            dcache_flush_ack_i[i] = 1'b1;
                            acked[i] = 1'b1;
                        end
                    end
                end
                if (flush_seen != 2'b00) wb_cnt++;
                wbuffer_empty_i = (wb_cnt >= wb_dly) ? 2'b11 : 2'b00;
                @(negedge clk_i);
                cyc++;
            end
        end
        core_halted_i      = 2'b00;
        dcache_flush_ack_i = 2'b00;
        wbuffer_empty_i    = 2'b11;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        mode_req_valid_i = 0; mode_req_dmr_i = 0; dmr_failure_i = 0; status_clear_i = 0;
        core_halted_i = 2'b00; dcache_flush_ack_i = 2'b00; wbuffer_empty_i = 2'b11;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({dmr_mode_active_o, core_halt_req_o, dcache_flush_o, core_rst_no, busy_o} !== 8'b0_00_00_11_0)
            $display("FAIL reset_ctrl: got mode/halt/flush/rst/busy=%b required 0_00_00_11_0",
                     {dmr_mode_active_o, core_halt_req_o, dcache_flush_o, core_rst_no, busy_o});
        else n_pass++;
        n_checks++;
        if ({fail_count_o, timeout_o, fatal_o, mode_req_ready_o} !== {8'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_status: got cnt=%0d tmo=%b fatal=%b rdy=%b required 0 0 0 1",
                     fail_count_o, timeout_o, fatal_o, mode_req_ready_o);
        else n_pass++;
    endtask

    // Drives one transition-causing event (request or failure) and checks it against the model.
    task automatic test_transition(input string name, input bit is_fail, input bit req_mode);
        logic [1:0] fs; int rl; logic mp, mr, hok, dn;
        int old_mode = ref_mode;
        int exp_mode;
        logic [1:0] exp_flush = (ref_mode == 1) ? 2'b01 : 2'b11;
        if (is_fail) begin
            if (ref_cnt < 255) ref_cnt++;
            if (ref_cnt >= 3) begin ref_fatal = 1; exp_mode = 0; end
            else exp_mode = 1;
        end else exp_mode = req_mode;
        @(negedge clk_i);
        mode_req_valid_i = 1'b1;
        mode_req_dmr_i   = is_fail ? ~req_mode : req_mode;
        dmr_failure_i    = is_fail;
        #1;
        n_checks++;
        if (mode_req_ready_o !== !is_fail)
            $display("FAIL %s_ready: got %b required %b", name, mode_req_ready_o, !is_fail);
        else n_pass++;
        run_transition($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
                       fs, rl, mp, mr, hok, dn);
        ref_mode = exp_mode;
        n_checks++;
        if (!dn || fs !== exp_flush || rl != 4 || !hok)
            $display("FAIL %s_seq: got done=%b flush=%b rst_cycles=%0d halt_ok=%b required 1 %b 4 1",
                     name, dn, fs, rl, hok, exp_flush);
        else n_pass++;
        n_checks++;
        if (mp !== old_mode[0] || mr !== exp_mode[0] || dmr_mode_active_o !== exp_mode[0])
            $display("FAIL %s_mode: got pre=%b at_rst=%b final=%b required %0d %0d %0d",
                     name, mp, mr, dmr_mode_active_o, old_mode, exp_mode, exp_mode);
        else n_pass++;
        n_checks++;
        if (fail_count_o !== ref_cnt[7:0] || fatal_o !== ref_fatal[0] || core_halt_req_o !== 2'b00)
            $display("FAIL %s_status: got cnt=%0d fatal=%b halt=%b required %0d %0d 00",
                     name, fail_count_o, fatal_o, core_halt_req_o, ref_cnt, ref_fatal);
        else n_pass++;
    endtask

    task automatic test_status_clear();
        @(negedge clk_i); status_clear_i = 1'b1;
        @(negedge clk_i); status_clear_i = 1'b0;
        ref_cnt = 0; ref_fatal = 0; ref_tmo = 0;
        n_checks++;
        if (fail_count_o !== 8'd0 || fatal_o !== 1'b0 || timeout_o !== 1'b0)
            $display("FAIL status_clear: got cnt=%0d fatal=%b tmo=%b required 0 0 0", fail_count_o, fatal_o, timeout_o);
        else n_pass++;
    endtask

    task automatic test_no_transition(input string name, input bit is_fail, input bit req_mode);
        bit saw_busy = 0;
        @(negedge clk_i);
        mode_req_valid_i = !is_fail; mode_req_dmr_i = req_mode; dmr_failure_i = is_fail;
        #1;
        n_checks++;
        if (mode_req_ready_o !== 1'b1) $display("FAIL %s_ready: got %b required 1", name, mode_req_ready_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            mode_req_valid_i = 0; dmr_failure_i = 0;
            if (busy_o) saw_busy = 1;
        end
        n_checks++;
        if (saw_busy || dmr_mode_active_o !== ref_mode[0] || fail_count_o !== ref_cnt[7:0])
            $display("FAIL %s_idle: got busy_seen=%b mode=%b cnt=%0d required 0 %0d %0d",
                     name, saw_busy, dmr_mode_active_o, fail_count_o, ref_mode, ref_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc = 1;
        bit rst_seen = 0;
        @(negedge clk_i); mode_req_valid_i = 1; mode_req_dmr_i = 1;
        @(negedge clk_i); mode_req_valid_i = 0; core_halted_i = 2'b01;
        while (!timeout_o && cyc < 1200) begin
            if (core_rst_no != 2'b11) rst_seen = 1;
            @(negedge clk_i); cyc++;
        end
        ref_tmo = 1;
        n_checks++;
        if (cyc < 1020 || cyc > 1030) $display("FAIL timeout_latency: got %0d cycles required about 1024", cyc);
        else n_pass++;
        n_checks++;
        if (timeout_o !== 1 || busy_o !== 0 || core_halt_req_o !== 2'b00 || dmr_mode_active_o !== 0 || rst_seen)
            $display("FAIL timeout_state: got tmo=%b busy=%b halt=%b mode=%b rst_seen=%b required 1 0 00 0 0",
                     timeout_o, busy_o, core_halt_req_o, dmr_mode_active_o, rst_seen);
        else n_pass++;
        core_halted_i = 2'b00;
    endtask

    task automatic test_recovery_timeout();
        int cyc = 0;
        int rl = 0;
        @(negedge clk_i); dmr_failure_i = 1;
        @(negedge clk_i); dmr_failure_i = 0; core_halted_i = 2'b01;
        while (!timeout_o && cyc < 1200) begin @(negedge clk_i); cyc++; end
        while (busy_o && cyc < 1300) begin
            if (core_rst_no == 2'b00) rl++;
            @(negedge clk_i); cyc++;
        end
        ref_cnt++; ref_fatal = 1; ref_tmo = 1; ref_mode = 0;
        n_checks++;
        if (timeout_o !== 1 || fatal_o !== 1 || rl != 4 || dmr_mode_active_o !== 0 || fail_count_o !== ref_cnt[7:0])
            $display("FAIL recovery_timeout: got tmo=%b fatal=%b rst_cycles=%0d mode=%b cnt=%0d required 1 1 4 0 %0d",
                     timeout_o, fatal_o, rl, dmr_mode_active_o, fail_count_o, ref_cnt);
        else n_pass++;
        core_halted_i = 2'b00;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            bit is_fail = ($urandom_range(0, 2) == 0);
            bit req     = 1'($urandom_range(0, 1));
            if (is_fail ? (ref_mode == 1) : (int'(req) != ref_mode)) test_transition("rand", is_fail, req);
            else test_no_transition("rand_noop", is_fail, req);
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        if (ref_mode == 1) test_transition("to_indep", 0, 0);
        @(negedge clk_i); mode_req_valid_i = 1; mode_req_dmr_i = 1;
        @(negedge clk_i); mode_req_valid_i = 0; core_halted_i = 2'b11; wbuffer_empty_i = 2'b00;
        while (dcache_flush_o == 2'b00 && cyc < 20) begin @(negedge clk_i); cyc++; end
        n_checks++;
        if (dcache_flush_o !== 2'b11) $display("FAIL async_flush_reached: got %b required 11", dcache_flush_o);
        else n_pass++;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({dmr_mode_active_o, core_halt_req_o, dcache_flush_o, core_rst_no, busy_o, timeout_o, fatal_o} !== 10'b0_00_00_11_0_0_0)
            $display("FAIL async_reset: got %b required 0000011000",
                     {dmr_mode_active_o, core_halt_req_o, dcache_flush_o, core_rst_no, busy_o, timeout_o, fatal_o});
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1; core_halted_i = 2'b00; wbuffer_empty_i = 2'b11;
        ref_mode = 0; ref_cnt = 0; ref_fatal = 0; ref_tmo = 0;
    endtask

    initial begin
        test_reset();
        test_transition("enter_dmr", 0, 1);
        for (int k = 0; k < 3; k++) test_transition("failure", 1, 1);
        test_status_clear();
        test_no_transition("fail_in_indep", 1, 0);
        test_no_transition("same_mode", 0, 0);
        test_timeout();
        test_status_clear();
        test_transition("reenter_dmr", 0, 1);
        test_recovery_timeout();
        test_status_clear();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
